// File: rtl/core_pkg.sv
// core_pkg: shared types and encodings for the multi-cycle RV64 control path.
package core_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
   } state_e;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
   localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
   localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] imm_src;
      logic [1:0] result_src;
      logic       reg_write;
   } ctrl_t;
   function automatic state_e dec_next(input logic [6:0] op);
      return (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
             (op == OP_R)   ? S_EXECR  :
             (op == OP_I)   ? S_EXECI  :
             (op == OP_BR)  ? S_BRANCH :
             (op == OP_JAL) ? S_JAL    : S_TRAP;
   endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory strobes and status.
interface multicycle_ctrl_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        adr_src;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  imm_src;
   logic [1:0]  result_src;
   logic        reg_write;
   logic        illegal;
   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, ir_write, pc_write, pc_src, adr_src, alu_src_a, alu_src_b,
             alu_op, imm_src, result_src, reg_write, illegal
   );
   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, ir_write, pc_write, pc_src, adr_src, alu_src_a, alu_src_b,
             alu_op, imm_src, result_src, reg_write, illegal
   );
endinterface

// File: rtl/ctrl_out_dec.sv
// ctrl_out_dec: combinational strobe decode from state, latched fields and status inputs.
module ctrl_out_dec
   import core_pkg::*;
(
   input  state_e     state_i,
   input  logic [6:0] op_i,
   input  logic [2:0] f3_i,
   input  logic [6:0] instr_op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
            ctrl_o.alu_src_a = SRCA_PC;
            ctrl_o.alu_src_b = SRCB_4;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            // old PC + imm precomputes the branch/jump target
            ctrl_o.alu_src_a = SRCA_OLDPC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.imm_src   = (instr_op_i == OP_BR) ? IMM_B : (instr_op_i == OP_JAL) ? IMM_J : IMM_I;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.imm_src   = (op_i == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.result_src = RES_MEM;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.mem_we  = 1'b1;
            ctrl_o.adr_src = 1'b1;
         end
         S_EXECR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.imm_src   = IMM_I;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.result_src = RES_ALU;
            ctrl_o.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.alu_op    = ALU_SUB;
            ctrl_o.pc_src    = 1'b1;
            ctrl_o.pc_write  = (f3_i == 3'b000) ? zero_i : (f3_i == 3'b001) ? !zero_i : 1'b0;
         end
         S_JAL: begin
            ctrl_o.imm_src    = IMM_J;
            ctrl_o.result_src = RES_PC4;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.pc_src     = 1'b1;
            ctrl_o.pc_write   = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle instruction sequencer driving the shared RV64 datapath.
module multicycle_ctrl
   import core_pkg::*;
#(
   parameter int RESET_HOLD = 1
) (
   input logic              clk,
   input logic              rst_n,
   multicycle_ctrl_if.master bus
);
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [6:0]    op_q, op_d;
   logic [2:0]    f3_q, f3_d;
   logic          illegal_q, illegal_d;
   ctrl_t         ctrl;
   logic          unused_instr;
   assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      op_d      = op_q;
      f3_d      = f3_q;
      case (state_q)
         S_IDLE: begin
            state_d = (hold_q == HW'(RESET_HOLD - 1)) ? S_FETCH : S_IDLE;
            hold_d  = (hold_q == HW'(RESET_HOLD - 1)) ? hold_q : hold_q + 1'b1;
         end
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            op_d    = bus.instr[6:0];
            f3_d    = bus.instr[14:12];
            state_d = dec_next(bus.instr[6:0]);
         end
         S_MEMADR:   state_d = (op_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: state_d = S_FETCH;
         default:    state_d = S_TRAP;
      endcase
      illegal_d = illegal_q | (state_d == S_TRAP);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         op_q      <= '0;
         f3_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         op_q      <= op_d;
         f3_q      <= f3_d;
         illegal_q <= illegal_d;
      end
   end
   ctrl_out_dec u_dec (
      .state_i     (state_q),
      .op_i        (op_q),
      .f3_i        (f3_q),
      .instr_op_i  (bus.instr[6:0]),
      .zero_i      (bus.zero),
      .mem_ready_i (bus.mem_ready),
      .ctrl_o      (ctrl)
   );
   assign {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src, bus.adr_src,
           bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src, bus.result_src,
           bus.reg_write} = ctrl;
   assign bus.illegal = illegal_q;
endmodule
